// File: rtl/jtag_master.sv
// Host-side JTAG initiator: shifts 1-32 bit TMS/TDI vectors out on a divided TCK
// and returns the TDO bits sampled at the end of each TCK high phase.
module jtag_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RESP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_len, w_len_nxt;
  logic [31:0] r_tms_vec, w_tms_vec_nxt;
  logic [31:0] r_tdi_vec, w_tdi_vec_nxt;
  logic [31:0] r_rsp_tdo, w_rsp_tdo_nxt;
  logic        r_tck, w_tck_nxt;
  logic        r_tms, w_tms_nxt;
  logic        r_tdi, w_tdi_nxt;
  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_busy;
  logic        r_tdo_s1, r_tdo_s2;
  logic        w_half_done;
  logic [4:0]  w_idx_inc;

  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_idx_inc   = r_idx + 5'd1;

  always_comb begin
    // NOTE: every target gets its hold value first so no path through the case infers a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_len_nxt       = r_len;
    w_tms_vec_nxt   = r_tms_vec;
    w_tdi_vec_nxt   = r_tdi_vec;
    w_rsp_tdo_nxt   = r_rsp_tdo;
    w_tck_nxt       = r_tck;
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_len_nxt       = cmd_len;
          w_tms_vec_nxt   = cmd_tms;
          w_tdi_vec_nxt   = cmd_tdi;
          w_idx_nxt       = 5'd0;
          w_cnt_nxt       = 8'd0;
          w_rsp_tdo_nxt   = 32'd0;
          w_cmd_ready_nxt = 1'b0;
          w_tck_nxt       = 1'b0;
          w_tms_nxt       = cmd_tms[0];
          w_tdi_nxt       = cmd_tdi[0];
          w_state_nxt     = S_LOW;
        end
      end
      S_LOW: begin
        if (w_half_done) begin
          w_cnt_nxt   = 8'd0;
          w_tck_nxt   = 1'b1;
          w_state_nxt = S_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HIGH: begin
        if (w_half_done) begin
          // Target moves TDO only on falling TCK, so the end of the high phase is settled.
          w_rsp_tdo_nxt[r_idx] = r_tdo_s2;
          w_cnt_nxt            = 8'd0;
          w_tck_nxt            = 1'b0;
          if (r_idx == r_len) begin
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_tms_nxt   = r_tms_vec[w_idx_inc];
            w_tdi_nxt   = r_tdi_vec[w_idx_inc];
            w_state_nxt = S_LOW;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_idx       <= 5'd0;
      r_len       <= 5'd0;
      r_tms_vec   <= 32'd0;
      r_tdi_vec   <= 32'd0;
      r_rsp_tdo   <= 32'd0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_tdo_s1    <= 1'b0;
      r_tdo_s2    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_tms_vec   <= w_tms_vec_nxt;
      r_tdi_vec   <= w_tdi_vec_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_tdo_s1    <= tdo;
      r_tdo_s2    <= r_tdo_s1;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_tdo   = r_rsp_tdo;
  assign busy      = r_busy;
  assign tck       = r_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// Randomized bench for jtag_master: a behavioural JTAG target drives TDO, and every
// command is checked for latency, pin sequence, TCK shape and captured TDO.
module tb_jtag_master;

  localparam int D = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        busy;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo = 1'b0;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Target model controls, written only by the stimulus process.
  bit          loop_mode = 1'b0;
  logic [31:0] tgt_pat   = 32'd0;
  int          base      = 0;

  // Pin monitor state, written only by the monitor process.
  int   rc       = 0;
  int   hi_run   = 0;
  int   mon_idx  = 0;
  logic prev_tck = 1'b0;
  logic tdi_d    = 1'b0;
  bit   q_tms[$];
  bit   q_tdi[$];
  int   q_hi[$];

  jtag_master #(.CLK_DIV(D)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_tms   (cmd_tms),
    .cmd_tdi   (cmd_tdi),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tdo   (rsp_tdo),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Records TMS/TDI at each TCK rise and high-phase lengths; the target changes TDO
  // only while TCK is low (pattern mode) or echoes TDI one cycle late (loopback).
  always @(negedge sys_clk) begin
    if (tck === 1'b1 && prev_tck !== 1'b1) begin
      q_tms.push_back(tms);
      q_tdi.push_back(tdi);
      rc++;
      hi_run = 1;
    end else if (tck === 1'b1) begin
      hi_run++;
    end
    if (tck === 1'b0 && prev_tck === 1'b1) q_hi.push_back(hi_run);
    if (loop_mode) begin
      tdo = tdi_d;
    end else if (tck === 1'b0) begin
      mon_idx = rc - base;
      tdo = (mon_idx >= 0 && mon_idx < 32) ? tgt_pat[mon_idx] : 1'b0;
    end
    tdi_d    = tdi;
    prev_tck = tck;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tck"},       tck,       1'b0);
    check({tag, "_tms"},       tms,       1'b1);
    check({tag, "_tdi"},       tdi,       1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_rsp_tdo"},   rsp_tdo,   32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response
  // handshake, so a following call issues back-to-back.
  task automatic run_cmd(input logic [4:0] len, input logic [31:0] vtms, input logic [31:0] vtdi,
                         input logic [31:0] pat, input bit lb, input int hold, output longint k);
    int          n       = int'(len) + 1;
    logic [31:0] mask    = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    logic [31:0] exp_tdo = (lb ? vtdi : pat) & mask;
    logic [31:0] got_tms = 32'd0;
    logic [31:0] got_tdi = 32'd0;
    logic [31:0] held;
    bit          stable  = 1'b1;
    bit          hi_ok   = 1'b1;
    int          waited  = 0;
    int          q0      = q_tms.size();
    int          h0      = q_hi.size();

    check("ready_before_cmd", cmd_ready, 1'b1);
    tgt_pat   = pat;
    loop_mode = lb;
    base      = rc;
    rsp_ready = (hold == 0);
    cmd_len   = len;
    cmd_tms   = vtms;
    cmd_tdi   = vtdi;
    cmd_valid = 1'b1;
    k         = cyc;
    do begin
      @(negedge sys_clk);
      waited++;
      if (rsp_valid !== 1'b1) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_len   = 5'($urandom);
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
      end
    end while (rsp_valid !== 1'b1 && waited < 2 * 32 * D + 20);
    cmd_valid = 1'b0;

    check("rsp_valid_seen", rsp_valid, 1'b1);
    if (rsp_valid === 1'b1) begin
      check("rsp_latency", cyc - k, 64'(1 + 2 * n * D));
      check("rsp_tdo", rsp_tdo, exp_tdo);
      held = rsp_tdo;
      for (int i = 0; i < hold; i++) begin
        @(negedge sys_clk);
        if (rsp_valid !== 1'b1 || rsp_tdo !== held || cmd_ready !== 1'b0 ||
            tck !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      end
      check("resp_hold_stable", stable, 1'b1);
      rsp_ready = 1'b1;
      @(negedge sys_clk);
      check("after_rsp_valid", rsp_valid, 1'b0);
      check("after_rsp_cmd_ready", cmd_ready, 1'b1);
      check("after_rsp_busy", busy, 1'b0);
      check("rise_count", q_tms.size() - q0, n);
      for (int i = 0; i < n && q0 + i < q_tms.size(); i++) begin
        got_tms[i] = q_tms[q0 + i];
        got_tdi[i] = q_tdi[q0 + i];
      end
      check("tms_bits", got_tms, vtms & mask);
      check("tdi_bits", got_tdi, vtdi & mask);
      for (int i = h0; i < q_hi.size(); i++) if (q_hi[i] != D) hi_ok = 1'b0;
      check("tck_high_len", hi_ok, 1'b1);
    end else begin
      rsp_ready = 1'b1;
      sys_rst   = 1'b1;
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    longint k1;
    longint k2;
    bit     quiet;

    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = 5'd0;
    cmd_tms   = 32'd0;
    cmd_tdi   = 32'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset("reset");

    // TAP reset sequence, then a back-to-back loopback shift
    run_cmd(5'd4, 32'h0000_001F, 32'd0, $urandom, 1'b0, 0, k1);
    run_cmd(5'd31, 32'd0, 32'hA5A5_0F0F, 32'd0, 1'b1, 0, k2);
    check("back_to_back", k2 - k1, 64'(2 * 5 * D + 2));

    // Partial length with TDO stuck high
    run_cmd(5'd7, $urandom, $urandom, 32'hFFFF_FFFF, 1'b0, 0, k1);

    // Response backpressure
    run_cmd(5'($urandom), $urandom, $urandom, $urandom, 1'b0, 10, k1);

    // Reset during bit 3 of a 16-bit command
    k2        = 64'(q_tms.size());
    cmd_len   = 5'd15;
    cmd_tms   = $urandom;
    cmd_tdi   = $urandom;
    cmd_valid = 1'b1;
    k1        = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    while (cyc - k1 < 64'(1 + 6 * D + 1)) @(negedge sys_clk);
    check("rises_before_reset", 64'(q_tms.size()) - k2, 64'd3);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_reset("mid_reset");
    quiet = 1'b1;
    repeat (2 * 16 * D + 10) begin
      @(negedge sys_clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || tck !== 1'b0) quiet = 1'b1 & 1'b0;
    end
    check("no_rsp_after_reset", quiet, 1'b1);
    run_cmd(5'd15, $urandom, $urandom, $urandom, 1'b0, 0, k1);

    // Randomized commands
    for (int t = 0; t < 24; t++) begin
      run_cmd(5'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0, k1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
